// File: rtl/stack_mem_unit_pkg.sv
// stack_mem_unit_pkg: shared widths, SP command encodings and stack bounds
package stack_mem_unit_pkg;
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
    localparam logic [7:0] DEF_SP_RESET = 8'hFF;
    localparam logic [7:0] DEF_STACK_FLOOR = 8'hE0;
    typedef enum logic [1:0] {
        RW_NONE = 2'b00,
        RW_PUSH = 2'b01,
        RW_POP  = 2'b10,
        RW_LSP  = 2'b11
    } rw_e;
endpackage

// File: rtl/dmem_sync_ram.sv
// dmem_sync_ram: single-port RAM with synchronous write and registered read
module dmem_sync_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // write the array and capture read data only when a read is requested
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/stack_mem_unit.sv
// stack_mem_unit: data memory, stack pointer and stack-guard flags
module stack_mem_unit
    import stack_mem_unit_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter logic [AW-1:0] SP_RESET = AW'(DEF_SP_RESET),
    parameter logic [AW-1:0] STACK_FLOOR = AW'(DEF_STACK_FLOOR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          wr,
    input  logic [1:0]    rw,
    input  logic          s50,
    input  logic [AW-1:0] or_addr,
    input  logic [DW-1:0] reg_data,
    input  logic [AW-1:0] npc,
    input  logic [DW-1:0] r0_data,
    input  logic          clr_flags,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic [AW-1:0] sp,
    output logic          stk_ovf,
    output logic          stk_unf,
    output logic          cmd_err
);
    logic [AW-1:0] sp_q, sp_d, ram_addr;
    logic          valid_q, valid_d, sel_q, sel_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
    logic          store, load, push, pop, lsp, idle, full, empty, we, re;
    logic [DW-1:0] wdata, ram_rdata;

    // decode the strobes, apply the stack guards and compute next state
    always_comb begin
        store    = wr && !rd && rw == RW_NONE;
        load     = rd && !wr && rw == RW_NONE;
        push     = wr && !rd && rw == RW_PUSH;
        pop      = rd && !wr && rw == RW_POP;
        lsp      = !rd && !wr && rw == RW_LSP;
        idle     = !rd && !wr && rw == RW_NONE;
        full     = sp_q == STACK_FLOOR - AW'(1);
        empty    = sp_q == SP_RESET;
        we       = store || (push && !full);
        re       = load || (pop && !empty);
        wdata    = s50 ? DW'(npc) : reg_data;
        ram_addr = push ? sp_q : pop ? sp_q + AW'(1) : or_addr;
        sp_d     = (push && !full) ? sp_q - AW'(1) :
                   (pop && !empty) ? sp_q + AW'(1) :
                   lsp ? AW'(r0_data) : sp_q;
        valid_d  = load || pop;
        sel_d    = re ? 1'b1 : (pop && empty) ? 1'b0 : sel_q;
        ovf_d    = (push && full) || (ovf_q && !clr_flags);
        unf_d    = (pop && empty) || (unf_q && !clr_flags);
        err_d    = !(store || load || push || pop || lsp || idle) || (err_q && !clr_flags);
    end

    // state registers; reset forces the stack and flags back immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q    <= SP_RESET;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    dmem_sync_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk   (clk),
        .we    (we),
        .re    (re),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    assign rdata       = sel_q ? ram_rdata : '0;
    assign rdata_valid = valid_q;
    assign sp          = sp_q;
    assign stk_ovf     = ovf_q;
    assign stk_unf     = unf_q;
    assign cmd_err     = err_q;
endmodule

// File: tb/tb_stack_mem_unit.sv
// tb_stack_mem_unit: scoreboard bench against a behavioural memory/stack model
module tb_stack_mem_unit;
    logic       clk = 0, rst = 1, rd = 0, wr = 0, s50 = 0, clr_flags = 0;
    logic [1:0] rw = 0;
    logic [7:0] or_addr = 0, reg_data = 0, npc = 0, r0_data = 0;
    logic [7:0] rdata, sp;
    logic       rdata_valid, stk_ovf, stk_unf, cmd_err;

    stack_mem_unit dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .rw(rw), .s50(s50),
        .or_addr(or_addr), .reg_data(reg_data), .npc(npc), .r0_data(r0_data),
        .clr_flags(clr_flags), .rdata(rdata), .rdata_valid(rdata_valid),
        .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [7:0] mem_m [256];
    logic [7:0] sp_m = 8'hFF;
    logic       ovf_m = 0, unf_m = 0, err_m = 0;
    logic [7:0] exp_q [$];
    logic [7:0] last_exp = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("sp", sp, sp_m);
        chk("stk_ovf", 8'(stk_ovf), 8'(ovf_m));
        chk("stk_unf", 8'(stk_unf), 8'(unf_m));
        chk("cmd_err", 8'(cmd_err), 8'(err_m));
    endtask

    // one command per cycle: check state before it, drive it, advance the model
    task automatic cmd(input logic r, input logic w, input logic [1:0] c, input logic s,
                       input logic [7:0] a, input logic [7:0] d, input logic [7:0] n,
                       input logic [7:0] z, input logic cl);
        logic [7:0] wd;
        logic bad, os, us;
        @(negedge clk);
        check_state();
        rd = r; wr = w; rw = c; s50 = s; or_addr = a; reg_data = d; npc = n; r0_data = z; clr_flags = cl;
        wd  = s ? n : d;
        bad = (r && w) || (c == 2'b01 && (!w || r)) || (c == 2'b10 && (!r || w)) || (c == 2'b11 && (r || w));
        os = 0; us = 0;
        if (!bad) begin
            case (c)
                2'b00: begin
                    if (w) mem_m[a] = wd;
                    if (r) exp_q.push_back(mem_m[a]);
                end
                2'b01: if (sp_m == 8'hDF) os = 1; else begin mem_m[sp_m] = wd; sp_m = sp_m - 1; end
                2'b10: if (sp_m == 8'hFF) begin us = 1; exp_q.push_back(8'h00); end
                       else begin sp_m = sp_m + 1; exp_q.push_back(mem_m[sp_m]); end
                default: sp_m = z;
            endcase
        end
        ovf_m = os || (ovf_m && !cl);
        unf_m = us || (unf_m && !cl);
        err_m = bad || (err_m && !cl);
        @(posedge clk);
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d); cmd(0, 1, 2'b00, 0, a, d, 0, 0, 0); endtask
    task automatic load(input logic [7:0] a); cmd(1, 0, 2'b00, 0, a, 0, 0, 0, 0); endtask
    task automatic push(input logic [7:0] d); cmd(0, 1, 2'b01, 0, 0, d, 0, 0, 0); endtask
    task automatic pop(); cmd(1, 0, 2'b10, 0, 0, 0, 0, 0, 0); endtask
    task automatic lsp(input logic [7:0] z); cmd(0, 0, 2'b11, 0, 0, 0, 0, z, 0); endtask
    task automatic idle(input logic cl); cmd(0, 0, 2'b00, 0, 0, 0, 0, 0, cl); endtask

    // monitor: pops the scoreboard on every valid read and checks hold otherwise
    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_exp = 0;
            chk("rdata_in_reset", rdata, 8'h00);
            chk("valid_in_reset", 8'(rdata_valid), 8'h00);
        end else if (rdata_valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 8'(rdata_valid), 8'h00);
            else begin
                last_exp = exp_q.pop_front();
                chk("rdata", rdata, last_exp);
            end
        end else chk("rdata_hold", rdata, last_exp);
    end

    initial begin
        logic [7:0] a;
        int k;
        repeat (2) @(negedge clk);
        chk("sp_reset", sp, 8'hFF);
        check_state();
        #2 rst = 0;
        for (int i = 0; i < 256; i++) store(8'(i), 8'($urandom));
        store(8'h10, 8'hA5);
        load(8'h10);
        cmd(0, 1, 2'b01, 1, 0, 8'h11, 8'h3C, 0, 0);
        load(8'hFF);
        pop();
        for (int i = 0; i < 32; i++) push(8'(i));
        push(8'hAA);
        load(8'hDF);
        for (int i = 0; i < 32; i++) pop();
        pop();
        idle(1);
        idle(0);
        lsp(8'hE5);
        push(8'h77);
        load(8'hE5);
        cmd(1, 1, 2'b00, 0, 8'h40, 8'h99, 0, 0, 0);
        load(8'h40);
        idle(1);
        for (int i = 0; i < 2000; i++) begin
            k = $urandom_range(0, 99);
            a = 8'($urandom);
            if (k < 20) store(a, 8'($urandom));
            else if (k < 40) load(a);
            else if (k < 58) cmd(0, 1, 2'b01, 1'($urandom), 0, 8'($urandom), 8'($urandom), 0, 0);
            else if (k < 76) pop();
            else if (k < 82) lsp($urandom_range(0, 3) == 0 ? a : 8'($urandom_range(8'hDC, 8'hFF)));
            else if (k < 90) idle($urandom_range(0, 7) == 0);
            else cmd(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), a, 8'($urandom),
                     8'($urandom), 8'($urandom), $urandom_range(0, 15) == 0);
        end
        lsp(8'hE1);
        cmd(1, 1, 2'b10, 0, 0, 0, 0, 0, 0);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        #2 rst = 1;
        rd = 0; wr = 0; rw = 0; clr_flags = 0;
        #1;
        sp_m = 8'hFF; ovf_m = 0; unf_m = 0; err_m = 0;
        check_state();
        @(negedge clk);
        #2 rst = 0;
        push(8'h5A);
        pop();
        idle(0);
        idle(0);
        check_state();
        chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
